memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
Pipeline stage directly downstream of the execute stage. Consumes the execute outputs (ce, opcode, ALU value, destination register) plus the store operand. Performs byte/half/word loads and stores against a data memory over a req/ack handshake, stalling upstream while an access is outstanding. Presents a registered result to writeback.

Parameters:
TIMEOUT, 16, max WAIT cycles without ack before the access is abandoned (>=1)
CNT_WIDTH, 5, width of the timeout counter; must hold TIMEOUT

Ports:
ms_clk  in  1  clock
ms_rst  in  1  reset; one clock, synchronous, active-high
ms_i_ce  in  1  upstream instruction valid
ms_i_opcode  in  OPCODE_WIDTH  opcode from execute
ms_i_alu_value  in  DWIDTH  ALU result; byte address for load/store
ms_i_store_data  in  DWIDTH  rt operand for stores
ms_i_addr_rd  in  AWIDTH  destination register
ms_o_stall  out  1  upstream must hold; combinational = (state==WAIT)
ms_o_mem_req  out  1  memory request, registered
ms_o_mem_we  out  1  1=store
ms_o_mem_addr  out  DWIDTH  word-aligned address {addr[DWIDTH-1:2],2'b00}
ms_o_mem_wdata  out  DWIDTH  lane-replicated store data
ms_o_mem_be  out  4  byte enables
ms_i_mem_ack  in  1  memory completion; rdata valid same cycle
ms_i_mem_rdata  in  DWIDTH  read word
ms_o_ce  out  1  result valid to writeback, one-cycle pulse
ms_o_value  out  DWIDTH  writeback data
ms_o_addr_rd  out  AWIDTH  writeback destination
ms_o_regwrite  out  1  write register file
ms_o_opcode  out  OPCODE_WIDTH  opcode passed through
ms_o_misalign  out  1  pulse with ms_o_ce: misaligned access suppressed
ms_o_timeout  out  1  pulse with ms_o_ce: access abandoned

Behaviour:
- Reset: state IDLE; every output 0; counter 0. Reset in WAIT drops ms_o_mem_req at the reset edge. Ack arriving in IDLE is ignored.
- States: IDLE, WAIT. Instruction accepted only in IDLE with ms_i_ce=1. Inputs presented during WAIT are ignored (upstream holds them).
- Non-memory op accepted: next edge ms_o_ce=1, value=alu_value, regwrite=(addr_rd!=0); stays IDLE. Latency 1.
- Misaligned: LW/SW addr[1:0]!=0; LH/LHU/SH addr[0]!=0. No memory access. Next edge ms_o_ce=1, ms_o_misalign=1, regwrite=0.
- Aligned load/store accepted: next edge req=1, we, addr, be, wdata registered; counter=0; ->WAIT.
- Lanes, little-endian, off=addr[1:0]:
  - SB: wdata={4{d[7:0]}}, be=4'b0001<<off.
  - SH: wdata={2{d[15:0]}}, be=addr[1]?1100:0011.
  - SW: be=1111.
  - Loads: byte=rdata>>(8*off); LB/LH sign-extend; LBU/LHU zero-extend.
- Request fields are held stable in WAIT until ack or timeout.
- WAIT with ack: next edge req=0, ms_o_ce=1, ->IDLE.
  - Load: value=extended data, regwrite=(addr_rd!=0).
  - Store: value=0, regwrite=0.
- Minimum memory-op latency: accept edge to ms_o_ce is 2 edges.
- WAIT without ack: counter++. When counter==TIMEOUT-1 and no ack: next edge req=0, ms_o_ce=1, ms_o_timeout=1, regwrite=0, ->IDLE.
- Ack on the final timeout cycle counts as success.
- ms_o_ce/misalign/timeout are one-cycle pulses. Otherwise value/addr_rd/opcode hold their last value.

Decomposition:
- Shared header (header.vh): opcode constants LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011; BE_WIDTH=4; state encodings.
- One combinational sub-module: mem_align.
  - Inputs: opcode, offset, store data, rdata.
  - Outputs: be, wdata, extended load value, misalign flag.
  - Shared by the store and load paths.

Test Plan:
- ALU op: ce=1, opcode 000000, alu_value=0x1234, rd=5 -> next cycle ce=1, value=0x1234, regwrite=1, stall never high.
- LB, addr=0x103, rdata=0x80FF_FF00, ack on first req cycle -> req addr 0x100, ce two cycles after accept, value=0xFFFFFF80; same with LBU -> 0x00000080.
- SH, addr=0x22, store_data=0xABCD1234, ack after 3 cycles -> be=1100, wdata=0x12341234, we=1, stall high 3 cycles, then ce=1 with regwrite=0.
- LW, addr=0x41 -> no req, ce=1, misalign=1, regwrite=0, next cycle after accept.
- LW, TIMEOUT=4, ack never -> req high 4 cycles then drops, ce=1 with timeout=1, regwrite=0; a late ack is ignored.
- Reset asserted in WAIT -> req=0 and stall=0 after the edge; a following ALU op completes normally.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared widths, load/store opcodes and FSM encoding for the memory stage.
package memory_stage_pkg;

  localparam int DWIDTH       = 32;
  localparam int AWIDTH       = 5;
  localparam int OPCODE_WIDTH = 6;
  localparam int BE_WIDTH     = 4;

  localparam logic [OPCODE_WIDTH-1:0] OP_LB  = 6'b100000;
  localparam logic [OPCODE_WIDTH-1:0] OP_LH  = 6'b100001;
  localparam logic [OPCODE_WIDTH-1:0] OP_LW  = 6'b100011;
  localparam logic [OPCODE_WIDTH-1:0] OP_LBU = 6'b100100;
  localparam logic [OPCODE_WIDTH-1:0] OP_LHU = 6'b100101;
  localparam logic [OPCODE_WIDTH-1:0] OP_SB  = 6'b101000;
  localparam logic [OPCODE_WIDTH-1:0] OP_SH  = 6'b101001;
  localparam logic [OPCODE_WIDTH-1:0] OP_SW  = 6'b101011;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  function automatic logic is_load(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/memory_stage_mem_align.sv
// Lane steering: byte enables, replicated store data, load extraction/extension
// and alignment check. Purely combinational.
module memory_stage_mem_align
  import memory_stage_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  input  logic [1:0]              offset_i,
  input  logic [DWIDTH-1:0]       store_data_i,
  input  logic [DWIDTH-1:0]       rdata_i,
  output logic [BE_WIDTH-1:0]     be_o,
  output logic [DWIDTH-1:0]       wdata_o,
  output logic [DWIDTH-1:0]       load_value_o,
  output logic                    misalign_o
);

  logic [DWIDTH-1:0] shifted;

  always_comb begin
    shifted      = rdata_i >> {offset_i, 3'b000};
    be_o         = '0;
    wdata_o      = '0;
    load_value_o = '0;
    misalign_o   = 1'b0;
    case (opcode_i)
      OP_LB:  load_value_o = {{(DWIDTH-8){shifted[7]}}, shifted[7:0]};
      OP_LBU: load_value_o = {{(DWIDTH-8){1'b0}}, shifted[7:0]};
      OP_LH: begin
        load_value_o = {{(DWIDTH-16){shifted[15]}}, shifted[15:0]};
        misalign_o   = offset_i[0];
      end
      OP_LHU: begin
        load_value_o = {{(DWIDTH-16){1'b0}}, shifted[15:0]};
        misalign_o   = offset_i[0];
      end
      OP_LW: begin
        load_value_o = rdata_i;
        misalign_o   = (offset_i != 2'b00);
      end
      OP_SB: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      OP_SH: begin
        be_o       = offset_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{store_data_i[15:0]}};
        misalign_o = offset_i[0];
      end
      OP_SW: begin
        be_o       = 4'b1111;
        wdata_o    = store_data_i;
        misalign_o = (offset_i != 2'b00);
      end
      default: ;
    endcase
    // Loads read the whole word; the lane is picked out on the way back.
    if (is_load(opcode_i)) be_o = 4'b1111;
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues load/store over req/ack, stalls upstream while
// waiting, abandons after TIMEOUT cycles, and registers the writeback result.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic                    ms_clk,
  input  logic                    ms_rst,
  input  logic                    ms_i_ce,
  input  logic [OPCODE_WIDTH-1:0] ms_i_opcode,
  input  logic [DWIDTH-1:0]       ms_i_alu_value,
  input  logic [DWIDTH-1:0]       ms_i_store_data,
  input  logic [AWIDTH-1:0]       ms_i_addr_rd,
  output logic                    ms_o_stall,
  output logic                    ms_o_mem_req,
  output logic                    ms_o_mem_we,
  output logic [DWIDTH-1:0]       ms_o_mem_addr,
  output logic [DWIDTH-1:0]       ms_o_mem_wdata,
  output logic [BE_WIDTH-1:0]     ms_o_mem_be,
  input  logic                    ms_i_mem_ack,
  input  logic [DWIDTH-1:0]       ms_i_mem_rdata,
  output logic                    ms_o_ce,
  output logic [DWIDTH-1:0]       ms_o_value,
  output logic [AWIDTH-1:0]       ms_o_addr_rd,
  output logic                    ms_o_regwrite,
  output logic [OPCODE_WIDTH-1:0] ms_o_opcode,
  output logic                    ms_o_misalign,
  output logic                    ms_o_timeout
);

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [1:0]              off_q, off_d;
  logic                    req_q, req_d, we_q, we_d;
  logic [DWIDTH-1:0]       addr_q, addr_d, wdata_q, wdata_d, value_q, value_d;
  logic [BE_WIDTH-1:0]     be_q, be_d;
  logic                    ce_q, ce_d, regwrite_q, regwrite_d;
  logic                    misalign_q, misalign_d, timeout_q, timeout_d;
  logic [AWIDTH-1:0]       addr_rd_q, addr_rd_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;

  logic [OPCODE_WIDTH-1:0] al_opcode;
  logic [1:0]              al_offset;
  logic [BE_WIDTH-1:0]     al_be;
  logic [DWIDTH-1:0]       al_wdata, al_load;
  logic                    al_misalign;

  // In WAIT the aligner serves the held load; in IDLE it checks the incoming op.
  assign al_opcode = (state_q == S_WAIT) ? opcode_q : ms_i_opcode;
  assign al_offset = (state_q == S_WAIT) ? off_q : ms_i_alu_value[1:0];

  memory_stage_mem_align u_align (
    .opcode_i     (al_opcode),
    .offset_i     (al_offset),
    .store_data_i (ms_i_store_data),
    .rdata_i      (ms_i_mem_rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .load_value_o (al_load),
    .misalign_o   (al_misalign)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    off_d      = off_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    value_d    = value_q;
    addr_rd_d  = addr_rd_q;
    opcode_d   = opcode_q;
    ce_d       = 1'b0;
    regwrite_d = 1'b0;
    misalign_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ms_i_ce) begin
          opcode_d  = ms_i_opcode;
          addr_rd_d = ms_i_addr_rd;
          if (!is_load(ms_i_opcode) && !is_store(ms_i_opcode)) begin
            ce_d       = 1'b1;
            value_d    = ms_i_alu_value;
            regwrite_d = (ms_i_addr_rd != '0);
          end else if (al_misalign) begin
            ce_d       = 1'b1;
            misalign_d = 1'b1;
            value_d    = '0;
          end else begin
            req_d   = 1'b1;
            we_d    = is_store(ms_i_opcode);
            addr_d  = {ms_i_alu_value[DWIDTH-1:2], 2'b00};
            be_d    = al_be;
            wdata_d = al_wdata;
            off_d   = ms_i_alu_value[1:0];
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Ack wins over timeout, including on the last counted cycle.
        if (ms_i_mem_ack) begin
          req_d   = 1'b0;
          ce_d    = 1'b1;
          state_d = S_IDLE;
          if (is_load(opcode_q)) begin
            value_d    = al_load;
            regwrite_d = (addr_rd_q != '0);
          end else begin
            value_d = '0;
          end
        end else if (cnt_q == CNT_WIDTH'(TIMEOUT - 1)) begin
          req_d     = 1'b0;
          ce_d      = 1'b1;
          timeout_d = 1'b1;
          value_d   = '0;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ms_clk) begin
    if (ms_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      off_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      value_q    <= '0;
      addr_rd_q  <= '0;
      opcode_q   <= '0;
      ce_q       <= 1'b0;
      regwrite_q <= 1'b0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      off_q      <= off_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      value_q    <= value_d;
      addr_rd_q  <= addr_rd_d;
      opcode_q   <= opcode_d;
      ce_q       <= ce_d;
      regwrite_q <= regwrite_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

  assign ms_o_stall     = (state_q == S_WAIT);
  assign ms_o_mem_req   = req_q;
  assign ms_o_mem_we    = we_q;
  assign ms_o_mem_addr  = addr_q;
  assign ms_o_mem_wdata = wdata_q;
  assign ms_o_mem_be    = be_q;
  assign ms_o_ce        = ce_q;
  assign ms_o_value     = value_q;
  assign ms_o_addr_rd   = addr_rd_q;
  assign ms_o_regwrite  = regwrite_q;
  assign ms_o_opcode    = opcode_q;
  assign ms_o_misalign  = misalign_q;
  assign ms_o_timeout   = timeout_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage (TIMEOUT=4): inputs driven and outputs sampled on negedge.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    i_ce = 1'b0;
  logic [OPCODE_WIDTH-1:0] i_opcode = '0;
  logic [DWIDTH-1:0]       i_alu = '0;
  logic [DWIDTH-1:0]       i_sdata = '0;
  logic [AWIDTH-1:0]       i_rd = '0;
  logic                    i_ack = 1'b0;
  logic [DWIDTH-1:0]       i_rdata = '0;
  logic                    o_stall, o_req, o_we, o_ce, o_regwrite, o_misalign, o_timeout;
  logic [DWIDTH-1:0]       o_addr, o_wdata, o_value;
  logic [BE_WIDTH-1:0]     o_be;
  logic [AWIDTH-1:0]       o_rd;
  logic [OPCODE_WIDTH-1:0] o_opcode;

  int n_vec = 0;
  int n_err = 0;

  memory_stage #(.TIMEOUT(4), .CNT_WIDTH(5)) dut (
    .ms_clk          (clk),
    .ms_rst          (rst),
    .ms_i_ce         (i_ce),
    .ms_i_opcode     (i_opcode),
    .ms_i_alu_value  (i_alu),
    .ms_i_store_data (i_sdata),
    .ms_i_addr_rd    (i_rd),
    .ms_o_stall      (o_stall),
    .ms_o_mem_req    (o_req),
    .ms_o_mem_we     (o_we),
    .ms_o_mem_addr   (o_addr),
    .ms_o_mem_wdata  (o_wdata),
    .ms_o_mem_be     (o_be),
    .ms_i_mem_ack    (i_ack),
    .ms_i_mem_rdata  (i_rdata),
    .ms_o_ce         (o_ce),
    .ms_o_value      (o_value),
    .ms_o_addr_rd    (o_rd),
    .ms_o_regwrite   (o_regwrite),
    .ms_o_opcode     (o_opcode),
    .ms_o_misalign   (o_misalign),
    .ms_o_timeout    (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({o_stall, o_req, o_we, o_ce, o_regwrite, o_misalign, o_timeout} !== 7'b0) begin
      n_err++; $display("FAIL reset_flags got %b want 0",
        {o_stall, o_req, o_we, o_ce, o_regwrite, o_misalign, o_timeout});
    end
    n_vec++;
    if ({o_addr, o_wdata, o_value, o_be, o_rd, o_opcode} !== '0) begin
      n_err++; $display("FAIL reset_buses got addr=%h wdata=%h value=%h be=%b rd=%0d op=%b want 0",
        o_addr, o_wdata, o_value, o_be, o_rd, o_opcode);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu(input logic [4:0] rd, input logic [31:0] val, input logic exp_rw);
    i_ce = 1'b1; i_opcode = 6'b000000; i_alu = val; i_rd = rd;
    #1;
    n_vec++;
    if (o_stall !== 1'b0) begin n_err++; $display("FAIL alu_stall got %b want 0", o_stall); end
    @(negedge clk);
    i_ce = 1'b0;
    n_vec++;
    if ({o_ce, o_regwrite, o_misalign, o_timeout, o_req, o_stall} !== {1'b1, exp_rw, 4'b0000}) begin
      n_err++; $display("FAIL alu_flags got ce=%b rw=%b mis=%b to=%b req=%b stall=%b want ce=1 rw=%b rest 0",
        o_ce, o_regwrite, o_misalign, o_timeout, o_req, o_stall, exp_rw);
    end
    n_vec++;
    if (o_value !== val || o_rd !== rd) begin
      n_err++; $display("FAIL alu_result got value=%h rd=%0d want value=%h rd=%0d", o_value, o_rd, val, rd);
    end
    @(negedge clk);
    n_vec++;
    if (o_ce !== 1'b0 || o_value !== val) begin
      n_err++; $display("FAIL alu_pulse got ce=%b value=%h want ce=0 value=%h", o_ce, o_value, val);
    end
  endtask

  // Load with ack on the first request cycle.
  task automatic test_load(input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_val);
    i_ce = 1'b1; i_opcode = op; i_alu = addr; i_rd = 5'd7;
    @(negedge clk);
    i_ce = 1'b0;
    n_vec++;
    if ({o_req, o_we, o_stall, o_ce} !== 4'b1010 || o_addr !== {addr[31:2], 2'b00}) begin
      n_err++; $display("FAIL load_req op=%b got req=%b we=%b stall=%b ce=%b addr=%h want 1010 addr=%h",
        op, o_req, o_we, o_stall, o_ce, o_addr, {addr[31:2], 2'b00});
    end
    i_ack = 1'b1; i_rdata = rdata;
    @(negedge clk);
    i_ack = 1'b0;
    n_vec++;
    if ({o_ce, o_regwrite, o_req, o_stall, o_timeout} !== 5'b11000 || o_value !== exp_val || o_rd !== 5'd7) begin
      n_err++; $display("FAIL load_result op=%b got ce=%b rw=%b req=%b stall=%b to=%b value=%h rd=%0d want 11000 value=%h rd=7",
        op, o_ce, o_regwrite, o_req, o_stall, o_timeout, o_value, o_rd, exp_val);
    end
  endtask

  task automatic test_store_sh();
    i_ce = 1'b1; i_opcode = OP_SH; i_alu = 32'h22; i_sdata = 32'hABCD1234; i_rd = 5'd3;
    @(negedge clk);
    i_ce = 1'b0; i_sdata = 32'hDEADBEEF;
    for (int c = 1; c <= 3; c++) begin
      n_vec++;
      if ({o_req, o_we, o_stall, o_ce} !== 4'b1110 || o_be !== 4'b1100 ||
          o_wdata !== 32'h12341234 || o_addr !== 32'h20) begin
        n_err++; $display("FAIL sh_wait%0d got req=%b we=%b stall=%b ce=%b be=%b wdata=%h addr=%h want 1110 be=1100 wdata=12341234 addr=20",
          c, o_req, o_we, o_stall, o_ce, o_be, o_wdata, o_addr);
      end
      if (c == 3) i_ack = 1'b1;
      @(negedge clk);
    end
    i_ack = 1'b0;
    n_vec++;
    if ({o_ce, o_regwrite, o_req, o_stall} !== 4'b1000 || o_value !== 32'h0) begin
      n_err++; $display("FAIL sh_done got ce=%b rw=%b req=%b stall=%b value=%h want 1000 value=0",
        o_ce, o_regwrite, o_req, o_stall, o_value);
    end
  endtask

  task automatic test_store_sb();
    i_ce = 1'b1; i_opcode = OP_SB; i_alu = 32'h45; i_sdata = 32'h000000A5;
    @(negedge clk);
    i_ce = 1'b0;
    n_vec++;
    if (o_be !== 4'b0010 || o_wdata !== 32'hA5A5A5A5 || o_we !== 1'b1 || o_addr !== 32'h44) begin
      n_err++; $display("FAIL sb_req got be=%b wdata=%h we=%b addr=%h want be=0010 wdata=a5a5a5a5 we=1 addr=44",
        o_be, o_wdata, o_we, o_addr);
    end
    i_ack = 1'b1;
    @(negedge clk);
    i_ack = 1'b0;
    n_vec++;
    if (o_ce !== 1'b1 || o_regwrite !== 1'b0) begin
      n_err++; $display("FAIL sb_done got ce=%b rw=%b want ce=1 rw=0", o_ce, o_regwrite);
    end
  endtask

  task automatic test_misalign(input logic [5:0] op, input logic [31:0] addr);
    i_ce = 1'b1; i_opcode = op; i_alu = addr; i_rd = 5'd9;
    @(negedge clk);
    i_ce = 1'b0;
    n_vec++;
    if ({o_ce, o_misalign, o_regwrite, o_req, o_stall, o_timeout} !== 6'b110000) begin
      n_err++; $display("FAIL misalign op=%b got ce=%b mis=%b rw=%b req=%b stall=%b to=%b want 110000",
        op, o_ce, o_misalign, o_regwrite, o_req, o_stall, o_timeout);
    end
    @(negedge clk);
    n_vec++;
    if (o_ce !== 1'b0 || o_misalign !== 1'b0) begin
      n_err++; $display("FAIL misalign_pulse got ce=%b mis=%b want 0 0", o_ce, o_misalign);
    end
  endtask

  // ack_cycle 0 = never acked; otherwise ack in that WAIT cycle (1..4).
  task automatic test_timeout(input int ack_cycle);
    int req_cycles;
    req_cycles = 0;
    i_ce = 1'b1; i_opcode = OP_LW; i_alu = 32'h80; i_rd = 5'd4; i_rdata = 32'hCAFEF00D;
    @(negedge clk);
    i_ce = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (o_req === 1'b1 && o_ce === 1'b0) req_cycles++;
      if (c == ack_cycle) i_ack = 1'b1;
      @(negedge clk);
    end
    i_ack = 1'b0;
    n_vec++;
    if (req_cycles != 4) begin
      n_err++; $display("FAIL timeout_req_len ack=%0d got %0d cycles want 4", ack_cycle, req_cycles);
    end
    n_vec++;
    if (ack_cycle == 0) begin
      if ({o_ce, o_timeout, o_regwrite, o_req, o_stall} !== 5'b11000) begin
        n_err++; $display("FAIL timeout_abandon got ce=%b to=%b rw=%b req=%b stall=%b want 11000",
          o_ce, o_timeout, o_regwrite, o_req, o_stall);
      end
      i_ack = 1'b1;
      @(negedge clk);
      i_ack = 1'b0;
      n_vec++;
      if ({o_ce, o_req, o_stall, o_timeout} !== 4'b0000) begin
        n_err++; $display("FAIL late_ack got ce=%b req=%b stall=%b to=%b want 0000",
          o_ce, o_req, o_stall, o_timeout);
      end
    end else begin
      if ({o_ce, o_timeout, o_regwrite, o_req} !== 4'b1010 || o_value !== 32'hCAFEF00D) begin
        n_err++; $display("FAIL last_cycle_ack got ce=%b to=%b rw=%b req=%b value=%h want 1010 value=cafef00d",
          o_ce, o_timeout, o_regwrite, o_req, o_value);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    i_ce = 1'b1; i_opcode = OP_LW; i_alu = 32'h100;
    @(negedge clk);
    i_ce = 1'b0;
    n_vec++;
    if (o_req !== 1'b1 || o_stall !== 1'b1) begin
      n_err++; $display("FAIL rstwait_pre got req=%b stall=%b want 1 1", o_req, o_stall);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({o_req, o_stall, o_ce} !== 3'b000) begin
      n_err++; $display("FAIL rstwait_post got req=%b stall=%b ce=%b want 000", o_req, o_stall, o_ce);
    end
    test_alu(5'd0, 32'h0000BEEF, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_alu(5'd5, 32'h00001234, 1'b1);
    test_load(OP_LB,  32'h103, 32'h80FFFF00, 32'hFFFFFF80);
    test_load(OP_LBU, 32'h103, 32'h80FFFF00, 32'h00000080);
    test_load(OP_LH,  32'h102, 32'h80010000, 32'hFFFF8001);
    test_load(OP_LHU, 32'h100, 32'h1234F00F, 32'h0000F00F);
    test_load(OP_LW,  32'h200, 32'h89ABCDEF, 32'h89ABCDEF);
    test_store_sh();
    test_store_sb();
    test_misalign(OP_LW, 32'h41);
    test_misalign(OP_SH, 32'h23);
    test_timeout(0);
    test_timeout(4);
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
